my_ram_fill_engine: RTL and testbench

//   Sequencer upstream of the 512x16 RAM. Owns the RAM's addr/in/load inputs during a block

---
 rtl/my_ram_fill_pkg.sv | 15 +
 rtl/my_ram_fill_addr_gen.sv | 41 ++++
 rtl/my_ram_fill_engine.sv | 164 ++++++++++++++++
 tb/tb_my_ram_fill_engine.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/my_ram_fill_pkg.sv
// Shared types and RAM geometry for the RAM block-fill engine.
package my_ram_fill_pkg;

    localparam int RAM_ADDR_W = 9;
    localparam int RAM_DATA_W = 16;
    localparam int RAM_DEPTH  = 512;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } fill_state_t;

endpackage

// File: rtl/my_ram_fill_addr_gen.sv
// Word index counter with address/data generation for the fill engine.
// Address wraps mod 2**ADDR_W, data wraps mod 2**DATA_W.
module my_ram_fill_addr_gen
    import my_ram_fill_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] pattern,
    input  logic              mode,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] idx;

    // Index counter: clear has priority over step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (step) begin
            idx <= idx + ONE;
        end
    end

    assign addr = base + idx[ADDR_W-1:0];
    assign data = mode ? (pattern + DATA_W'(idx)) : pattern;
    assign last = (idx == (len - ONE));

endmodule

// File: rtl/my_ram_fill_engine.sv
// Block-fill sequencer that owns the RAM addr/in/load bus during a fill.
// Optional read-back verify pass and mismatch counter: MY_RAM_FILL_VERIFY_EN.
//
// state  | meaning
// IDLE   | waiting for start, RAM bus outputs held at 0
// WRITE  | one RAM write per cycle over base..base+len-1
// VERIFY | read-back compare over the same range (verify build only)
// DONE   | one-cycle done pulse, then back to IDLE
module my_ram_fill_engine
    import my_ram_fill_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] pattern,
    input  logic [DATA_W-1:0] ram_out,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   mism_cnt
);

    fill_state_t       state, next_state;
    logic              start_ok;
    logic              mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] pattern_q;
    logic              gen_clear, gen_step, gen_last;
    logic [ADDR_W-1:0] gen_addr;
    logic [DATA_W-1:0] gen_data;

    assign start_ok = (state == IDLE) && start;

    my_ram_fill_addr_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (gen_clear),
        .step    (gen_step),
        .base    (base_q),
        .len     (len_q),
        .pattern (pattern_q),
        .mode    (mode_q),
        .addr    (gen_addr),
        .data    (gen_data),
        .last    (gen_last)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operand latches, loaded only on an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            pattern_q <= '0;
        end else if (start_ok) begin
            mode_q    <= mode;
            base_q    <= base;
            len_q     <= len;
            pattern_q <= pattern;
        end
    end

    // Next-state decode and RAM bus / status outputs.
    always_comb begin
        next_state = state;
        gen_clear  = 1'b0;
        gen_step   = 1'b0;
        ram_addr   = '0;
        ram_in     = '0;
        ram_load   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                gen_clear = 1'b1;
                if (start) begin
                    next_state = (len == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                ram_addr = gen_addr;
                ram_in   = gen_data;
                ram_load = 1'b1;
                if (gen_last) begin
                    gen_clear  = 1'b1;
`ifdef MY_RAM_FILL_VERIFY_EN
                    next_state = VERIFY;
`else
                    next_state = DONE;
`endif
                end else begin
                    gen_step = 1'b1;
                end
            end
`ifdef MY_RAM_FILL_VERIFY_EN
            VERIFY: begin
                ram_addr = gen_addr;
                if (gen_last) begin
                    gen_clear  = 1'b1;
                    next_state = DONE;
                end else begin
                    gen_step = 1'b1;
                end
            end
`endif
            DONE: begin
                done       = 1'b1;
                gen_clear  = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

`ifdef MY_RAM_FILL_VERIFY_EN
    localparam logic [ADDR_W:0] MISM_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] MISM_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] mism_q;

    // Saturating mismatch counter; cleared by an accepted start, held after DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mism_q <= '0;
        end else if (start_ok) begin
            mism_q <= '0;
        end else if ((state == VERIFY) && (ram_out != gen_data) && (mism_q != MISM_MAX)) begin
            mism_q <= mism_q + MISM_ONE;
        end
    end

    assign mism_cnt = mism_q;
`else
    logic unused_ram_out;

    assign unused_ram_out = ^ram_out;
    assign mism_cnt       = '0;
`endif

endmodule

// File: tb/tb_my_ram_fill_engine.sv
// Self-checking bench for my_ram_fill_engine driving a behavioural 512x16 RAM.
// Expected writes are queued when a fill is launched and popped per RAM load.
module tb_my_ram_fill_engine;

    localparam int AW = 9;
    localparam int DW = 16;
`ifdef MY_RAM_FILL_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          mode;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [DW-1:0] pattern;
    logic [DW-1:0] ram_out;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_in;
    logic          ram_load;
    logic          busy;
    logic          done;
    logic [AW:0]   mism_cnt;

    logic [DW-1:0] mem  [512];
    logic [DW-1:0] flip [512];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk   = 0;
    int  n_fail  = 0;
    int  n_loads = 0;

    my_ram_fill_engine dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .base     (base),
        .len      (len),
        .pattern  (pattern),
        .ram_out  (ram_out),
        .ram_addr (ram_addr),
        .ram_in   (ram_in),
        .ram_load (ram_load),
        .busy     (busy),
        .done     (done),
        .mism_cnt (mism_cnt)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous write, combinational read; flip[] injects corruption.
    always @(posedge clk) begin
        if (ram_load) mem[ram_addr] <= ram_in;
    end
    assign ram_out = mem[ram_addr] ^ flip[ram_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: each RAM load is matched against the next queued write.
    always @(negedge clk) begin
        wr_t e;
        if (ram_load === 1'b1) begin
            n_loads++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_load", 32'(ram_load), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_addr", 32'(ram_addr), 32'(e.addr));
                chk("sb_data", 32'(ram_in), 32'(e.data));
            end
        end
    end

    function automatic int done_cyc(input int l);
        if (l == 0) return 1;
        return VERIFY ? (2 * l + 1) : (l + 1);
    endfunction

    task automatic start_fill(input logic [AW-1:0] b, input logic [AW:0] l,
                              input logic m, input logic [DW-1:0] p);
        wr_t w;
        for (int i = 0; i < int'(l); i++) begin
            w.addr = b + AW'(i);
            w.data = m ? (p + DW'(i)) : p;
            exp_q.push_back(w);
        end
        @(negedge clk);
        base    = b;
        len     = l;
        mode    = m;
        pattern = p;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles after the start edge until done; optionally pokes a start mid-fill.
    task automatic wait_done(input string tag, input int exp_cyc, input int cyc0, input int intr_cyc);
        int cyc;
        bit seen;
        cyc  = cyc0;
        seen = 1'b0;
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk({tag, "_busy1"}, 32'(busy), 32'd1);
            if (done === 1'b1) seen = 1'b1;
            if (intr_cyc != 0 && cyc == intr_cyc) begin
                start   = 1'b1;
                base    = 9'd300;
                len     = 10'd3;
                pattern = 16'h5555;
            end
            if (intr_cyc != 0 && cyc == intr_cyc + 1) start = 1'b0;
        end
        chk({tag, "_done_cyc"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_cyc));
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nz;
        int loads0;
        for (int i = 0; i < 512; i++) flip[i] = '0;
        reset   = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        base    = '0;
        len     = '0;
        pattern = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_load",     32'(ram_load), 32'd0);
        chk("rst_addr",     32'(ram_addr), 32'd0);
        chk("rst_in",       32'(ram_in),   32'd0);
        chk("rst_mism",     32'(mism_cnt), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: clear the whole RAM
        start_fill(9'd0, 10'd512, 1'b0, 16'h0000);
        wait_done("t1", done_cyc(512), 0, 0);
        nz = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== 16'h0000) nz++;
        chk("t1_mem_nonzero", 32'(nz), 32'd0);
        chk("t1_loads", 32'(n_loads), 32'd512);
        chk("t1_mism", 32'(mism_cnt), 32'd0);

        // 2: incrementing pattern wrapping in both address and data
        start_fill(9'd510, 10'd4, 1'b1, 16'hFFFE);
        wait_done("t2", done_cyc(4), 0, 0);
        chk("t2_mem510", 32'(mem[510]), 32'h0000_FFFE);
        chk("t2_mem511", 32'(mem[511]), 32'h0000_FFFF);
        chk("t2_mem0",   32'(mem[0]),   32'h0000_0000);
        chk("t2_mem1",   32'(mem[1]),   32'h0000_0001);
        chk("t2_mem2",   32'(mem[2]),   32'h0000_0000);

        // 3: zero-length request
        loads0 = n_loads;
        start_fill(9'd5, 10'd0, 1'b0, 16'h1234);
        @(negedge clk);
        chk("t3_done_c1", 32'(done),     32'd1);
        chk("t3_busy_c1", 32'(busy),     32'd1);
        chk("t3_load_c1", 32'(ram_load), 32'd0);
        @(negedge clk);
        chk("t3_busy_c2", 32'(busy), 32'd0);
        chk("t3_done_c2", 32'(done), 32'd0);
        chk("t3_no_loads", 32'(n_loads), 32'(loads0));

        // 4: start re-asserted mid-WRITE is ignored
        start_fill(9'd20, 10'd8, 1'b0, 16'hA5A5);
        wait_done("t4", done_cyc(8), 0, 3);
        chk("t4_mem27",  32'(mem[27]),  32'h0000_A5A5);
        chk("t4_mem28",  32'(mem[28]),  32'h0000_0000);
        chk("t4_mem300", 32'(mem[300]), 32'h0000_0000);

        // 5: reset after three of eight writes, then a fresh fill
        start_fill(9'd100, 10'd8, 1'b1, 16'h1234);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t5_load", 32'(ram_load), 32'd0);
        chk("t5_busy", 32'(busy),     32'd0);
        chk("t5_addr", 32'(ram_addr), 32'd0);
        chk("t5_in",   32'(ram_in),   32'd0);
        chk("t5_done", 32'(done),     32'd0);
        chk("t5_pending", 32'(exp_q.size()), 32'd5);
        exp_q.delete();
        @(negedge clk);
        chk("t5_mem102", 32'(mem[102]), 32'h0000_1236);
        chk("t5_mem103", 32'(mem[103]), 32'h0000_0000);
        reset = 1'b0;
        start_fill(9'd100, 10'd8, 1'b1, 16'h1234);
        wait_done("t5b", done_cyc(8), 0, 0);
        chk("t5b_mem103", 32'(mem[103]), 32'h0000_1237);
        chk("t5b_mem107", 32'(mem[107]), 32'h0000_123B);

`ifdef MY_RAM_FILL_VERIFY_EN
        // 6: corrupt two words between WRITE and VERIFY
        start_fill(9'd40, 10'd8, 1'b1, 16'h0100);
        repeat (8) @(posedge clk);
        #1;
        flip[42] = 16'h0001;
        flip[45] = 16'h8000;
        wait_done("t6", 17, 8, 0);
        chk("t6_mism", 32'(mism_cnt), 32'd2);
        repeat (3) @(negedge clk);
        chk("t6_mism_hold", 32'(mism_cnt), 32'd2);
        flip[42] = '0;
        flip[45] = '0;
        start_fill(9'd0, 10'd0, 1'b0, 16'h0000);
        @(negedge clk);
        chk("t6_mism_clear", 32'(mism_cnt), 32'd0);
        @(negedge clk);
`else
        chk("novfy_mism", 32'(mism_cnt), 32'd0);
`endif

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
